// File: rtl/discharge_pulse_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// discharge_pulse_timer
// Per-pulse EDM discharge sequencer. Applies gap voltage (WAIT), waits for
// breakdown, holds discharge current for Ton (ON), then rests for Toff (OFF),
// repeating while machining is enabled. Supports isopulse (Ton timed from
// breakdown) and isofrequency (Ton timed from gap-voltage application) modes.
//
// Ports:
//   clk            system clock
//   sys_rst        synchronous active-high reset, highest priority
//   is_machine     machining enable level; low aborts to IDLE on the next edge
//   Ton_data       on-time in ticks (0 treated as 1)
//   Toff_data      off-time in ticks (0 treated as 1)
//   Ip_data        peak-current reference, captured at each WAIT entry
//   waveform_data  bit0: 0 = isopulse, 1 = isofrequency; other bits ignored
//   breakdown_det  gap-breakdown level, already synchronous to clk
//   gate_hv        high-voltage switch gate (WAIT and ON)
//   current_en     discharge current enable (ON only)
//   ip_ref         peak-current reference of the pulse in progress
//   pulse_done     one-cycle strobe when an ON phase completes
//   open_pulse     one-cycle strobe when a breakdown wait times out
//   busy           high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module discharge_pulse_timer #(
  parameter int TICK_DIV       = 10,
  parameter int MAX_WAIT_TICKS = 1000
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        is_machine,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] Ip_data,
  input  logic [15:0] waveform_data,
  input  logic        breakdown_det,
  output logic        gate_hv,
  output logic        current_en,
  output logic [15:0] ip_ref,
  output logic        pulse_done,
  output logic        open_pulse,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_OFF  = 2'd3;

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CWR  = $clog2(MAX_WAIT_TICKS + 1);
  localparam int CW   = (CWR > 16) ? CWR : 16;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW:0]   WAIT_LIM  = (CW + 1)'(MAX_WAIT_TICKS);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [PW-1:0] presc_r;
  logic [CW-1:0] tick_cnt_r;
  logic [15:0]   ton_snap_r;
  logic [15:0]   toff_snap_r;
  logic          mode_snap_r;

  logic tick_s;
  logic ton_done_s;
  logic toff_done_s;
  logic wait_done_s;
  logic keep_timer_s;
  logic snap_s;
  logic done_evt_s;
  logic open_evt_s;
  logic waveform_unused;

  assign waveform_unused = ^waveform_data[15:1];

  // True when the tick about to be counted completes a phase of 'limit' ticks.
  function automatic logic phase_elapsed(input logic [CW-1:0] cnt,
                                         input logic [CW:0]   limit);
    phase_elapsed = (({1'b0, cnt} + (CW + 1)'(1)) >= limit);
  endfunction

  assign tick_s      = (presc_r == PRESC_MAX);
  assign ton_done_s  = tick_s && phase_elapsed(tick_cnt_r, (CW + 1)'(ton_snap_r));
  assign toff_done_s = tick_s && phase_elapsed(tick_cnt_r, (CW + 1)'(toff_snap_r));
  assign wait_done_s = tick_s && phase_elapsed(tick_cnt_r, WAIT_LIM);

  // Next-state decode; the machining-enable abort overrides every other event.
  always_comb begin
    state_nxt_s  = state_r;
    keep_timer_s = 1'b0;
    snap_s       = 1'b0;
    done_evt_s   = 1'b0;
    open_evt_s   = 1'b0;
    if (!is_machine) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nxt_s = S_WAIT;
          snap_s      = 1'b1;
        end
        S_WAIT: begin
          if (breakdown_det) begin
            state_nxt_s  = S_ON;
            // Isofrequency keeps timing Ton from the WAIT entry.
            keep_timer_s = mode_snap_r;
          end else if (mode_snap_r ? ton_done_s : wait_done_s) begin
            state_nxt_s = S_OFF;
            open_evt_s  = 1'b1;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_ON: begin
          if (ton_done_s) begin
            state_nxt_s = S_OFF;
            done_evt_s  = 1'b1;
          end else begin
            state_nxt_s = S_ON;
          end
        end
        S_OFF: begin
          if (toff_done_s) begin
            state_nxt_s = S_WAIT;
            snap_s      = 1'b1;
          end else begin
            state_nxt_s = S_OFF;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State, phase timer, parameter snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r     <= S_IDLE;
      presc_r     <= '0;
      tick_cnt_r  <= '0;
      ton_snap_r  <= 16'd1;
      toff_snap_r <= 16'd1;
      mode_snap_r <= 1'b0;
      gate_hv     <= 1'b0;
      current_en  <= 1'b0;
      ip_ref      <= 16'd0;
      pulse_done  <= 1'b0;
      open_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      if ((state_nxt_s != state_r) && !keep_timer_s) begin
        presc_r    <= '0;
        tick_cnt_r <= '0;
      end else if (state_r != S_IDLE) begin
        presc_r <= tick_s ? '0 : (presc_r + PW'(1));
        // Saturate rather than wrap so a long phase can never restart.
        if (tick_s && (tick_cnt_r != CNT_MAX)) begin
          tick_cnt_r <= tick_cnt_r + CW'(1);
        end
      end

      if (snap_s) begin
        ton_snap_r  <= (Ton_data  == 16'd0) ? 16'd1 : Ton_data;
        toff_snap_r <= (Toff_data == 16'd0) ? 16'd1 : Toff_data;
        mode_snap_r <= waveform_data[0];
        ip_ref      <= Ip_data;
      end else if (state_nxt_s == S_IDLE) begin
        ip_ref <= 16'd0;
      end

      // Outputs decode the next state so they are valid on the first cycle of it.
      gate_hv    <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_ON);
      current_en <= (state_nxt_s == S_ON);
      busy       <= (state_nxt_s != S_IDLE);
      pulse_done <= done_evt_s;
      open_pulse <= open_evt_s;
    end
  end

endmodule
